// File: rtl/lisp_defs.sv
// Shared Lisp heap definitions.
// Cell type tags and the NIL pointer value.
package lisp_defs;

    localparam logic [15:0] LISP_NIL = 16'h0000;

    localparam logic [14:0] TYPE_NUMBER = 15'd1;
    localparam logic [14:0] TYPE_CONS   = 15'd2;
    localparam logic [14:0] TYPE_SYMBOL = 15'd3;
    localparam logic [14:0] TYPE_STRING = 15'd4;

endpackage

// File: rtl/memory.sv
// Lisp cell heap: combinational read port plus a
// bump allocator that writes 3-word cells.
module memory
    import lisp_defs::*;
#(
    parameter int HeapStart  = 1,
    parameter int MemorySize = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] addr_in,
    output logic        data_ready,
    output logic [15:0] data_out,
    input  logic        write_enable,
    input  logic [14:0] data_type,
    input  logic [15:0] car_data,
    input  logic [15:0] cdr_data,
    output logic        write_done,
    output logic [15:0] ptr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W_HDR = 3'd1,
        W_CAR = 3'd2,
        W_CDR = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int          AW         = (MemorySize > 1) ? $clog2(MemorySize) : 1;
    localparam logic [16:0] MEM_SIZE   = 17'(MemorySize);
    localparam logic [15:0] HEAP_START = 16'(HeapStart);

    // Word 0 holds NIL; the rest of the heap starts cleared.
    logic [15:0] memory [0:MemorySize-1] = '{0: LISP_NIL, default: 16'h0000};

    state_t      r_state;
    logic [15:0] r_free;
    logic [14:0] r_type;
    logic [15:0] r_car;
    logic [15:0] r_cdr;
    logic        r_full;
    logic        r_done;
    logic [15:0] r_ptr;

    logic        w_full;
    logic        w_rd_hit;
    logic        w_wr_en;
    logic [15:0] w_wr_addr;
    logic [15:0] w_wr_data;

    // Full when a new cell would run past the last word.
    assign w_full = ({1'b0, r_free} + 17'd3) > MEM_SIZE;

    assign w_rd_hit   = req && ({1'b0, addr_in} < MEM_SIZE);
    assign data_ready = req;
    assign data_out   = w_rd_hit ? memory[addr_in[AW-1:0]] : 16'h0000;

    assign write_done = r_done;
    assign ptr        = r_ptr;

    // Allocation sequencer: latch cell, walk three writes, publish pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_free  <= HEAP_START;
            r_done  <= 1'b0;
            r_ptr   <= LISP_NIL;
            r_full  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (write_enable) begin
                        r_type  <= data_type;
                        r_car   <= car_data;
                        r_cdr   <= cdr_data;
                        r_full  <= w_full;
                        r_state <= w_full ? DONE : W_HDR;
                    end
                end
                W_HDR: r_state <= W_CAR;
                W_CAR: r_state <= W_CDR;
                W_CDR: r_state <= DONE;
                DONE: begin
                    r_done <= 1'b1;
                    if (r_full) begin
                        r_ptr <= LISP_NIL;
                    end else begin
                        r_ptr  <= r_free + 16'd2;
                        r_free <= r_free + 16'd3;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Select which word of the cell this state writes.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_free;
        w_wr_data = {1'b0, r_type};
        unique case (r_state)
            W_HDR: begin
                w_wr_en = 1'b1;
            end
            W_CAR: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_free + 16'd1;
                w_wr_data = r_car;
            end
            W_CDR: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_free + 16'd2;
                w_wr_data = r_cdr;
            end
            default: w_wr_en = 1'b0;
        endcase
    end

    // Array write port; a reset edge suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            memory[w_wr_addr[AW-1:0]] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed bench for the Lisp cell heap.
// Small heap (18 words) so the full condition is reachable.
module tb_memory;
    import lisp_defs::*;

    localparam int HS = 1;
    localparam int MS = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] addr_in = 16'h0000;
    logic        data_ready;
    logic [15:0] data_out;
    logic        write_enable = 1'b0;
    logic [14:0] data_type = 15'd0;
    logic [15:0] car_data = 16'h0000;
    logic [15:0] cdr_data = 16'h0000;
    logic        write_done;
    logic [15:0] ptr;

    int checks = 0;
    int errors = 0;

    memory #(.HeapStart(HS), .MemorySize(MS)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .addr_in(addr_in),
        .data_ready(data_ready),
        .data_out(data_out),
        .write_enable(write_enable),
        .data_type(data_type),
        .car_data(car_data),
        .cdr_data(cdr_data),
        .write_done(write_done),
        .ptr(ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe one allocation, measure latency to write_done, check ptr and pulse width.
    task automatic alloc(input string tag, input logic [14:0] t,
                         input logic [15:0] a, input logic [15:0] d,
                         input int lat, input logic [15:0] exp_ptr);
        int n;
        @(negedge clk);
        data_type    = t;
        car_data     = a;
        cdr_data     = d;
        write_enable = 1'b1;
        @(posedge clk); #1;
        write_enable = 1'b0;
        n = 0;
        while (!write_done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 16'(n), 16'(lat));
        chk({tag, "_ptr"}, ptr, exp_ptr);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {15'd0, write_done}, 16'd0);
    endtask

    initial begin
        int pulses;

        // Reset state and reads during reset
        repeat (2) @(posedge clk);
        #1;
        req = 1'b1;
        addr_in = 16'h0000;
        #1;
        chk("rst_done", {15'd0, write_done}, 16'd0);
        chk("rst_ptr", ptr, LISP_NIL);
        chk("rst_ready", {15'd0, data_ready}, 16'd1);
        chk("rst_mem0", data_out, LISP_NIL);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;

        // First two cells
        alloc("a1", TYPE_NUMBER, 16'hDEAD, LISP_NIL, 4, 16'h0003);
        chk("a1_hdr", dut.memory[1], 16'h0001);
        chk("a1_car", dut.memory[2], 16'hDEAD);
        chk("a1_cdr", dut.memory[3], 16'h0000);
        alloc("a2", TYPE_NUMBER, 16'hBEEF, LISP_NIL, 4, 16'h0006);

        // Combinational reads
        @(negedge clk);
        req = 1'b1;
        addr_in = 16'h0002;
        #1;
        chk("rd2_ready", {15'd0, data_ready}, 16'd1);
        chk("rd2_data", data_out, 16'hDEAD);
        addr_in = 16'h0005;
        #1;
        chk("rd5_data", data_out, 16'hBEEF);
        addr_in = 16'h0012;
        #1;
        chk("rd_oob", data_out, 16'h0000);
        addr_in = 16'h0002;
        req = 1'b0;
        #1;
        chk("rd_off_ready", {15'd0, data_ready}, 16'd0);
        chk("rd_off_data", data_out, 16'h0000);

        // Strobe again while in W_CAR: must be ignored
        @(negedge clk);
        data_type = TYPE_CONS;
        car_data = 16'h1234;
        cdr_data = 16'h5678;
        write_enable = 1'b1;
        @(posedge clk); #1;
        write_enable = 1'b0;
        @(posedge clk); #1;
        write_enable = 1'b1;
        @(posedge clk); #1;
        write_enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (write_done) pulses++;
            @(posedge clk); #1;
        end
        chk("rep_pulses", 16'(pulses), 16'd1);
        chk("rep_ptr", ptr, 16'h0009);
        chk("rep_hdr", dut.memory[7], 16'h0002);
        chk("rep_next", dut.memory[10], 16'h0000);

        // Reset while in W_CAR
        @(negedge clk);
        data_type = TYPE_SYMBOL;
        car_data = 16'h1111;
        cdr_data = 16'h2222;
        write_enable = 1'b1;
        @(posedge clk); #1;
        write_enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (write_done) pulses++;
            @(posedge clk); #1;
        end
        chk("rst_pulses", 16'(pulses), 16'd0);
        chk("rst_ptr2", ptr, LISP_NIL);
        chk("rst_kept_hdr", dut.memory[10], 16'h0003);
        chk("rst_no_car", dut.memory[11], 16'h0000);
        alloc("a_post", TYPE_NUMBER, 16'hCAFE, LISP_NIL, 4, 16'(HS + 2));
        chk("post_car", dut.memory[2], 16'hCAFE);

        // Fill up to free = MS-2, then the full case
        alloc("f1", TYPE_NUMBER, 16'h0A0A, 16'h0B0B, 4, 16'h0006);
        alloc("f2", TYPE_NUMBER, 16'h0C0C, 16'h0D0D, 4, 16'h0009);
        alloc("f3", TYPE_NUMBER, 16'h0E0E, 16'h0F0F, 4, 16'h000C);
        alloc("f4", TYPE_NUMBER, 16'h1010, 16'h7777, 4, 16'h000F);
        alloc("full", TYPE_NUMBER, 16'h9999, 16'h8888, 1, LISP_NIL);
        chk("full_m15", dut.memory[15], 16'h7777);
        chk("full_m16", dut.memory[16], 16'h0000);
        chk("full_m17", dut.memory[17], 16'h0000);
        alloc("full2", TYPE_NUMBER, 16'h9999, 16'h8888, 1, LISP_NIL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have parameter HeapStart, default 1: first word address of the cell heap.
REQ-002 SHALL have parameter MemorySize, default 1024: number of 16-bit words in the array, readable hierarchically as memory.MemorySize.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 1: read request.
REQ-006 SHALL have port addr_in, input, 16: read word address.
REQ-007 SHALL have port data_ready, output, 1: read data valid.
REQ-008 SHALL have port data_out, output, 16: read data.
REQ-009 SHALL have port write_enable, input, 1: one-cycle cell-allocate strobe.
REQ-010 SHALL have port data_type, input, 15: cell type tag.
REQ-011 SHALL have port car_data, input, 16: car word.
REQ-012 SHALL have port cdr_data, input, 16: cdr word.
REQ-013 SHALL have port write_done, output, 1: one-cycle allocation-complete pulse.
REQ-014 SHALL have port ptr, output, 16: pointer to the last allocated cell.

Function
REQ-015 Storage SHALL be an unpacked array named memory of MemorySize 16-bit words, accessible hierarchically for bench preload and clearing.
REQ-016 Read SHALL be combinational: data_ready = req; data_out = memory[addr_in] when req=1 and addr_in < MemorySize, otherwise 16'h0000.
REQ-017 Reads SHALL be independent of the write FSM and allowed in any state.
REQ-018 A word being written SHALL read its old value until the edge that writes it.
REQ-019 Cell layout at base B SHALL be: memory[B] = header {1'b0 mark bit, data_type}, memory[B+1] = car_data, memory[B+2] = cdr_data.
REQ-020 The returned cell pointer SHALL be B+2, so car is at ptr-1 and the header at ptr-2.
REQ-021 FSM states SHALL be IDLE, W_HDR, W_CAR, W_CDR and DONE.
REQ-022 In IDLE, write_enable=1 SHALL latch data_type, car_data and cdr_data into internal registers and go to W_HDR.
REQ-023 W_HDR, W_CAR and W_CDR SHALL each write one word at free, free+1 and free+2 respectively, one per cycle.
REQ-024 DONE SHALL assert write_done for exactly one cycle, set ptr = free+2, advance free by 3, and return to IDLE.
REQ-025 write_enable while not in IDLE SHALL be ignored, with no queuing.
REQ-026 Latency SHALL be 4 cycles from the edge sampling write_enable to the edge that raises write_done.
REQ-027 Heap full (free+3 > MemorySize when write_enable is sampled) SHALL write nothing, go directly to DONE, pulse write_done, set ptr = LISP_NIL and leave free unchanged.
REQ-028 ptr SHALL hold its value until the next DONE.

Reset
REQ-029 rst=1 at a clock edge SHALL set state to IDLE, free to HeapStart, write_done to 0 and ptr to LISP_NIL.
REQ-030 Reset mid-allocation SHALL abort the allocation; words already written SHALL remain and no write_done SHALL be issued.
REQ-031 Reset SHALL NOT clear the memory array.
REQ-032 Initial array contents SHALL be memory[0] = LISP_NIL and all other words 16'h0000.
REQ-033 data_ready and data_out SHALL follow REQ-016 during reset.

Structure
REQ-034 Shared package lisp_defs SHALL hold LISP_NIL (16'h0000) and the 15-bit type tags, including TYPE_NUMBER.
REQ-035 The FSM state enum SHALL be local to the module.
REQ-036 The design SHALL be a single module with no sub-modules.

Verification
REQ-037 Reset with HeapStart=1; allocate (TYPE_NUMBER, DEAD, NIL) -> write_done pulses 4 cycles after the strobe, ptr=0003, memory[1]={0,TYPE_NUMBER}, memory[3]=0000.
REQ-038 Second allocation (TYPE_NUMBER, BEEF, NIL) -> ptr=0006.
REQ-039 Reads: req=1, addr_in=0002 -> data_ready=1 and data_out=DEAD in the same cycle; addr_in=0005 -> data_out=BEEF; req=0 -> data_ready=0 and data_out=0000.
REQ-040 Set free to MemorySize-2, then allocate -> write_done pulses, ptr=0000, no words change.
REQ-041 write_enable re-pulsed during W_CAR -> exactly one cell allocated and one write_done pulse.
REQ-042 rst asserted in W_CAR -> no write_done; the next allocation starts at HeapStart (ptr=HeapStart+2).
